// File: rtl/ram_request_controller.sv
// Request front-end for a single-port-per-direction RAM: writes pass straight through,
// reads are issued to the RAM and their registered data is queued for in-order return.
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

module ram_request_controller #(
  parameter int WIDTH          = `TIA_WORD_WIDTH,
  parameter int DEPTH          = 1024,
  parameter int RESPONSE_DEPTH = 4,
  localparam int IW            = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             request_valid,
  output logic             request_ready,
  input  logic             request_write,
  input  logic [IW-1:0]    request_index,
  input  logic [WIDTH-1:0] request_data,
  output logic             response_valid,
  input  logic             response_ready,
  output logic [WIDTH-1:0] response_data,
  output logic             ram_read_enable,
  output logic [IW-1:0]    ram_read_index,
  input  logic [WIDTH-1:0] ram_read_data,
  output logic             ram_write_enable,
  output logic [IW-1:0]    ram_write_index,
  output logic [WIDTH-1:0] ram_write_data,
  output logic             idle
);

  localparam int PW = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;
  localparam int CW = $clog2(RESPONSE_DEPTH + 1);

  logic             r_inflight;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [RESPONSE_DEPTH];

  logic [CW-1:0]    w_occupancy;
  logic             w_read_ok;
  logic             w_read_accept;
  logic             w_write_accept;
  logic             w_resp_valid;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(RESPONSE_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Read admission counts the in-flight read so its data always has a slot;
  // it deliberately ignores response_ready to keep that path registered-only.
  assign w_occupancy    = r_count + CW'(r_inflight);
  assign w_read_ok      = w_occupancy < CW'(RESPONSE_DEPTH);
  assign request_ready  = !reset && (request_write || w_read_ok);

  assign w_read_accept  = request_valid && request_ready && !request_write;
  assign w_write_accept = request_valid && request_ready && request_write;

  assign ram_read_enable  = w_read_accept;
  assign ram_read_index   = w_read_accept ? request_index : '0;
  assign ram_write_enable = w_write_accept;
  assign ram_write_index  = w_write_accept ? request_index : '0;
  assign ram_write_data   = w_write_accept ? request_data : '0;

  assign w_resp_valid   = !reset && (r_count != '0);
  assign response_valid = w_resp_valid;
  assign response_data  = w_resp_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = r_inflight;
  assign w_pop  = w_resp_valid && response_ready;
  assign idle   = !r_inflight && (r_count == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_read_accept;
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: buffer storage is deliberately left out of reset; the cleared count
  // and pointers already make any stale contents unreachable.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= ram_read_data;
  end

endmodule

// File: tb/tb_ram_request_controller.sv
// Randomized and directed bench for ram_request_controller; a queue-based model
// predicts readiness, RAM strobes and the ordered read responses every cycle.
module tb_ram_request_controller;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 1024;
  localparam int RDEPTH = 4;
  localparam int IW     = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             request_valid = 1'b0;
  logic             request_ready;
  logic             request_write = 1'b0;
  logic [IW-1:0]    request_index = '0;
  logic [WIDTH-1:0] request_data = '0;
  logic             response_valid;
  logic             response_ready = 1'b0;
  logic [WIDTH-1:0] response_data;
  logic             ram_read_enable;
  logic [IW-1:0]    ram_read_index;
  logic [WIDTH-1:0] ram_read_data;
  logic             ram_write_enable;
  logic [IW-1:0]    ram_write_index;
  logic [WIDTH-1:0] ram_write_data;
  logic             idle;

  ram_request_controller #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESPONSE_DEPTH(RDEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_index(request_index),
    .request_data(request_data),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_data(response_data),
    .ram_read_enable(ram_read_enable), .ram_read_index(ram_read_index),
    .ram_read_data(ram_read_data),
    .ram_write_enable(ram_write_enable), .ram_write_index(ram_write_index),
    .ram_write_data(ram_write_data),
    .idle(idle)
  );

  always #5 clock = ~clock;

  // Behavioural RAM with a registered read port, driven only by the DUT strobes.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    if (ram_write_enable) ram_mem[ram_write_index] <= ram_write_data;
    if (ram_read_enable)  ram_read_data <= ram_mem[ram_read_index];
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    int               avail;
  } resp_t;

  resp_t            exp_q[$];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               cyc;
  int               n_vec;
  int               n_err;

  logic             obs_rdy;
  logic             obs_rv;
  logic             obs_wen;
  logic             obs_idle;
  logic [WIDTH-1:0] obs_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One modelled clock cycle: drive, check against the model, then advance it.
  task automatic cycle(input logic v, input logic w, input logic [IW-1:0] idx,
                       input logic [WIDTH-1:0] d, input logic rr);
    logic exp_rdy, exp_rv, exp_ren, exp_wen;
    @(negedge clock);
    request_valid  = v;
    request_write  = w;
    request_index  = idx;
    request_data   = d;
    response_ready = rr;
    #1;
    exp_rdy = w || (exp_q.size() < RDEPTH);
    exp_rv  = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    exp_ren = v && !w && exp_rdy;
    exp_wen = v && w;
    check("request_ready", 32'(request_ready), 32'(exp_rdy));
    check("response_valid", 32'(response_valid), 32'(exp_rv));
    if (exp_rv) check("response_data", response_data, exp_q[0].data);
    check("idle", 32'(idle), 32'(exp_q.size() == 0));
    check("ram_read_enable", 32'(ram_read_enable), 32'(exp_ren));
    check("ram_read_index", 32'(ram_read_index), exp_ren ? 32'(idx) : 32'd0);
    check("ram_write_enable", 32'(ram_write_enable), 32'(exp_wen));
    check("ram_write_index", 32'(ram_write_index), exp_wen ? 32'(idx) : 32'd0);
    check("ram_write_data", ram_write_data, exp_wen ? d : 32'd0);
    obs_rdy  = request_ready;
    obs_rv   = response_valid;
    obs_rd   = response_data;
    obs_wen  = ram_write_enable;
    obs_idle = idle;
    if (exp_rv && rr) void'(exp_q.pop_front());
    if (exp_ren) exp_q.push_back(resp_t'{data: ref_mem[idx], avail: cyc + 2});
    if (exp_wen) ref_mem[idx] = d;
    cyc++;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset          = 1'b1;
    request_valid  = 1'b1;
    request_write  = 1'b1;
    request_index  = 10'd5;
    request_data   = 32'hFFFF_FFFF;
    response_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      check("rst_request_ready", 32'(request_ready), 32'd0);
      check("rst_response_valid", 32'(response_valid), 32'd0);
      check("rst_ram_read_enable", 32'(ram_read_enable), 32'd0);
      check("rst_ram_write_enable", 32'(ram_write_enable), 32'd0);
      check("rst_response_data", response_data, 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      @(negedge clock);
    end
    reset          = 1'b0;
    request_valid  = 1'b0;
    request_write  = 1'b0;
    response_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int acc, nresp, first, last;
    logic rr;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;

    apply_reset(2);

    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, IW'(i), $urandom(), 1'b0);

    // Write then read index 5; data appears exactly two cycles after acceptance.
    cycle(1'b1, 1'b1, 10'd5, 32'hA5A5_0001, 1'b1);
    cycle(1'b1, 1'b0, 10'd5, 32'd0, 1'b1);
    check("req042_read_accept", 32'(obs_rdy), 32'd1);
    cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    check("req042_not_early", 32'(obs_rv), 32'd0);
    cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    check("req042_valid", 32'(obs_rv), 32'd1);
    check("req042_data", obs_rd, 32'hA5A5_0001);

    // Four back-to-back reads, responses contiguous and in order.
    nresp = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        cycle(1'b1, 1'b0, IW'(i + 1), 32'd0, 1'b1);
        check("req043_accept", 32'(obs_rdy), 32'd1);
      end else begin
        cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
      end
      if (obs_rv) begin
        nresp++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("req043_responses", 32'(nresp), 32'd4);
    check("req043_no_gaps", 32'(last - first + 1), 32'd4);

    // Stalled consumer: exactly RESPONSE_DEPTH reads get in.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, IW'(20 + i), 32'd0, 1'b0);
      if (obs_rdy) acc++;
    end
    check("req044_accepts", 32'(acc), 32'(RDEPTH));
    check("req044_blocked", 32'(obs_rdy), 32'd0);

    // Writes still go through with the buffer full.
    cycle(1'b1, 1'b1, 10'd30, $urandom(), 1'b0);
    check("req045_write_ready", 32'(obs_rdy), 32'd1);
    check("req045_write_strobe", 32'(obs_wen), 32'd1);

    // Pop one, refill via a read, then pop while that read's data is pushed.
    cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 10'd31, 32'd0, 1'b0);
    check("req046_refill_accept", 32'(obs_rdy), 32'd1);
    cycle(1'b1, 1'b0, 10'd32, 32'd0, 1'b1);
    check("req046_full_blocked", 32'(obs_rdy), 32'd0);
    check("req046_pop_valid", 32'(obs_rv), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    check("req046_drained", 32'(obs_idle), 32'd1);

    // Reset with two buffered entries and one read in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, IW'(10 + i), 32'd0, 1'b0);
    apply_reset(1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
      check("req047_no_stale", 32'(obs_rv), 32'd0);
      check("req047_idle", 32'(obs_idle), 32'd1);
    end

    // Random traffic with phases of light, medium and heavy backpressure.
    for (int k = 0; k < 3000; k++) begin
      int thresh;
      case ((k / 150) % 3)
        0:       thresh = 90;
        1:       thresh = 50;
        default: thresh = 10;
      endcase
      if (k == 1500) apply_reset(2);
      rr = ($urandom_range(0, 99) < thresh);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            IW'($urandom_range(0, 63)), $urandom(), rr);
    end

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 10'd0, 32'd0, 1'b1);
    check("final_idle", 32'(obs_idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
